// File: rtl/viterbi_update_pkg.sv
// Shared constants, score type, transition tables and FSM encoding for the
// Viterbi recursion stage that follows the Gaussian-mixture scorer.
package viterbi_update_pkg;
  localparam int STATE     = 12;
  localparam int SWIDTH    = 64;
  localparam int MAXFRAMES = 64;
  localparam int AW        = $clog2(MAXFRAMES);
  localparam int SW        = $clog2(STATE);
  localparam int IW        = $clog2(STATE + 1);

  typedef logic signed [SWIDTH-1:0] score_t;

  localparam score_t NEG_INF = -(64'sd1 <<< 62);

  localparam score_t LOG_A_SELF [STATE] = '{default: score_t'(-10)};
  localparam score_t LOG_A_FWD  [STATE] = '{default: score_t'(-20)};

  typedef enum logic [1:0] {IDLE, ACCUM, BACKTRACE} fsm_t;

  // Anything at or below NEG_INF stays pinned there so "impossible" paths never
  // climb back into range; ordinary sums are left unclamped.
  function automatic score_t sat_add(input score_t a, input score_t b);
    if (a <= NEG_INF || b <= NEG_INF) return NEG_INF;
    return a + b;
  endfunction
endpackage

// File: rtl/viterbi_update_if.sv
// Likelihood input stream and backtrace output stream of viterbi_update.
interface viterbi_update_if;
  import viterbi_update_pkg::*;

  logic        seq_start;
  logic        seq_end;
  logic        ll_valid;
  logic [15:0] ll_index;
  score_t      ll_in;
  logic        frame_done;
  logic        busy;
  score_t      best_score;
  logic        bt_valid;
  logic [15:0] bt_state;
  logic [15:0] bt_frame;
  logic        bt_done;
  logic        err;

  modport master (
    output seq_start, seq_end, ll_valid, ll_index, ll_in, frame_done,
    input  busy, best_score, bt_valid, bt_state, bt_frame, bt_done, err
  );

  modport slave (
    input  seq_start, seq_end, ll_valid, ll_index, ll_in, frame_done,
    output busy, best_score, bt_valid, bt_state, bt_frame, bt_done, err
  );
endinterface

// File: rtl/viterbi_update_bp.sv
// Backpointer store: one STATE-wide row per frame, single port, registered read.
module viterbi_bp_ram
  import viterbi_update_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [STATE-1:0] wdata,
  output logic [STATE-1:0] rdata
);
  logic [STATE-1:0] mem [MAXFRAMES];

  always_ff @(posedge clk)
    if (we) mem[addr] <= wdata;

  always_ff @(posedge clk or posedge reset)
    if (reset) rdata <= '0;
    else       rdata <= mem[addr];
endmodule

// File: rtl/viterbi_update.sv
// Left-to-right Viterbi recursion over the scorer's per-state likelihoods,
// followed by a backtrace that streams the best path from the last frame down.
module viterbi_update
  import viterbi_update_pkg::*;
(
  input  logic clk,
  input  logic reset,
  viterbi_update_if.slave bus
);
  fsm_t             state, state_nxt;
  score_t           prev [STATE];
  score_t           cur  [STATE];
  score_t           eff_prev [STATE];
  logic [STATE-1:0] cur_bp, rd_bp, bp_sh;
  logic [IW-1:0]    exp_idx, eff_idx;
  logic [AW:0]      frame_cnt;
  logic [AW-1:0]    ptr;
  logic [SW-1:0]    bt_cur, s_out, best_idx;
  logic             first, fd_q;
  logic             fd_edge, in_acc, commit_ok, eff_first, samp_ok, bp_bit;
  score_t           self_s, fwd_s, delta, best_val;

  assign fd_edge   = bus.frame_done & ~fd_q;
  assign in_acc    = (state == ACCUM) && !bus.seq_start && !bus.seq_end;
  assign commit_ok = in_acc && fd_edge && (exp_idx == IW'(STATE)) &&
                     (frame_cnt < (AW+1)'(MAXFRAMES));
  // A sample landing on the commit edge opens the next frame, so it must see
  // the row being committed as its predecessor, not the stale one.
  assign eff_idx   = fd_edge ? '0 : exp_idx;
  assign eff_first = commit_ok ? 1'b0 : (frame_cnt == '0);
  assign samp_ok   = (eff_idx < IW'(STATE)) && (bus.ll_index == 16'(eff_idx));

  always_comb
    for (int k = 0; k < STATE; k++) eff_prev[k] = commit_ok ? cur[k] : prev[k];

  always_comb begin
    self_s = NEG_INF;
    fwd_s  = NEG_INF;
    for (int k = 0; k < STATE; k++)
      if (eff_idx == IW'(k)) begin
        self_s = sat_add(eff_prev[k], LOG_A_SELF[k]);
        if (k > 0)
          fwd_s = sat_add(eff_prev[(k+STATE-1)%STATE], LOG_A_FWD[(k+STATE-1)%STATE]);
      end
    bp_bit = !eff_first && (fwd_s > self_s);
    if (eff_first) delta = (eff_idx == '0) ? bus.ll_in : NEG_INF;
    else           delta = sat_add(bp_bit ? fwd_s : self_s, bus.ll_in);
  end

  always_comb begin
    best_val = prev[0];
    best_idx = '0;
    for (int k = 1; k < STATE; k++)
      if (prev[k] > best_val) begin
        best_val = prev[k];
        best_idx = SW'(k);
      end
  end

  // First element is the argmax itself; later ones step back through the row
  // fetched for the frame just emitted.
  assign bp_sh = rd_bp >> bt_cur;
  assign s_out = first ? bt_cur : bt_cur - SW'(bp_sh[0]);

  viterbi_bp_ram u_bp (
    .clk   (clk),
    .reset (reset),
    .we    (commit_ok),
    .addr  (commit_ok ? AW'(frame_cnt) : ptr),
    .wdata (cur_bp),
    .rdata (rd_bp)
  );

  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else       state <= state_nxt;

  always_comb begin
    state_nxt = state;
    if (bus.seq_start) state_nxt = ACCUM;
    else
      case (state)
        ACCUM:     if (bus.seq_end) state_nxt = (frame_cnt == '0) ? IDLE : BACKTRACE;
        BACKTRACE: if (ptr == '0)   state_nxt = IDLE;
        default:   ;
      endcase
  end

  assign bus.busy = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < STATE; k++) begin
        prev[k] <= NEG_INF;
        cur[k]  <= NEG_INF;
      end
      cur_bp         <= '0;
      exp_idx        <= '0;
      frame_cnt      <= '0;
      ptr            <= '0;
      bt_cur         <= '0;
      first          <= 1'b0;
      fd_q           <= 1'b0;
      bus.best_score <= '0;
      bus.bt_valid   <= 1'b0;
      bus.bt_state   <= '0;
      bus.bt_frame   <= '0;
      bus.bt_done    <= 1'b0;
      bus.err        <= 1'b0;
    end else begin
      fd_q         <= bus.frame_done;
      bus.bt_valid <= 1'b0;
      bus.bt_done  <= 1'b0;
      if (bus.seq_start) begin
        for (int k = 0; k < STATE; k++) prev[k] <= NEG_INF;
        frame_cnt <= '0;
        exp_idx   <= '0;
        bus.err   <= 1'b0;
      end else if (state == ACCUM && bus.seq_end) begin
        bus.best_score <= (frame_cnt == '0) ? NEG_INF : best_val;
        bt_cur         <= best_idx;
        ptr            <= AW'(frame_cnt - 1'b1);
        first          <= 1'b1;
        if (frame_cnt == '0) bus.bt_done <= 1'b1;
      end else if (in_acc) begin
        if (commit_ok) begin
          for (int k = 0; k < STATE; k++) prev[k] <= cur[k];
          frame_cnt <= frame_cnt + 1'b1;
        end
        if (fd_edge) begin
          exp_idx <= '0;
          if (!commit_ok) bus.err <= 1'b1;
        end
        if (bus.ll_valid) begin
          if (samp_ok) begin
            for (int k = 0; k < STATE; k++)
              if (eff_idx == IW'(k)) begin
                cur[k]    <= delta;
                cur_bp[k] <= bp_bit;
              end
            exp_idx <= eff_idx + 1'b1;
          end else begin
            bus.err <= 1'b1;
          end
        end
      end else if (state == BACKTRACE) begin
        bus.bt_valid <= 1'b1;
        bus.bt_state <= 16'(s_out);
        bus.bt_frame <= 16'(ptr);
        bt_cur       <= s_out;
        first        <= 1'b0;
        ptr          <= ptr - 1'b1;
        if (ptr == '0) bus.bt_done <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_viterbi_update.sv
// Directed table, randomized sequences against a full-matrix Viterbi model,
// and hand-written error / overflow / reset-abort sequences.
module tb_viterbi_update;
  localparam int NS   = 12;
  localparam int MAXF = 64;
  localparam longint NEG = -(64'sd1 <<< 62);

  typedef longint frame_t [NS];
  typedef struct {
    int     nf;
    frame_t f0;
    frame_t f1;
    longint score;
    int     p0;
    int     p1;
  } dvec_t;

  logic clk = 1'b0;
  logic rst;
  int   errs = 0;
  int   checks = 0;

  frame_t mf[$];
  longint m_score;
  int     m_path[$];

  viterbi_update_if bus();
  viterbi_update dut (.clk(clk), .reset(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint sa(input longint a, input longint b);
    if (a <= NEG || b <= NEG) return NEG;
    return a + b;
  endfunction

  // Full trellis over every committed frame, then walk the stored choices back.
  function automatic void run_model();
    longint d [MAXF][NS];
    int     psi [MAXF][NS];
    int     nf = mf.size();
    int     b = 0;
    m_path.delete();
    m_score = NEG;
    if (nf == 0) return;
    for (int t = 0; t < nf; t++)
      for (int j = 0; j < NS; j++) begin
        psi[t][j] = 0;
        if (t == 0) d[t][j] = (j == 0) ? mf[0][0] : NEG;
        else begin
          longint s = sa(d[t-1][j], -10);
          longint f = (j > 0) ? sa(d[t-1][j-1], -20) : NEG;
          if (f > s) begin d[t][j] = sa(f, mf[t][j]); psi[t][j] = 1; end
          else d[t][j] = sa(s, mf[t][j]);
        end
      end
    for (int j = 1; j < NS; j++) if (d[nf-1][j] > d[nf-1][b]) b = j;
    m_score = d[nf-1][b];
    for (int t = nf - 1; t >= 0; t--) begin
      m_path.push_back(b);
      b = b - psi[t][b];
    end
  endfunction

  function automatic frame_t rand_frame();
    frame_t f;
    for (int k = 0; k < NS; k++) f[k] = longint'($urandom_range(0, 10)) * 10 - 50;
    return f;
  endfunction

  task automatic start_seq();
    bus.seq_start = 1'b1;
    step();
    bus.seq_start = 1'b0;
    mf.delete();
  endtask

  task automatic send_frame(input frame_t f, input bit keep);
    for (int k = 0; k < NS; k++) begin
      bus.ll_valid = 1'b1;
      bus.ll_index = 16'(k);
      bus.ll_in    = f[k];
      step();
    end
    bus.ll_valid   = 1'b0;
    bus.frame_done = 1'b1;
    step();
    bus.frame_done = 1'b0;
    step();
    if (keep) mf.push_back(f);
  endtask

  task automatic end_and_collect(input string tag);
    int n = 0;
    int nf = m_path.size();
    bit done = 1'b0;
    bus.seq_end = 1'b1;
    for (int c = 0; c < MAXF + 10 && !done; c++) begin
      step();
      if (c == 0) bus.seq_end = 1'b0;
      if (bus.bt_valid) begin
        if (n == 0) chk({tag, " first_lat"}, c, 1);
        chk($sformatf("%s frame[%0d]", tag, n), bus.bt_frame, nf - 1 - n);
        chk($sformatf("%s state[%0d]", tag, n), bus.bt_state, (n < nf) ? m_path[n] : -1);
        n++;
      end
      if (bus.bt_done) begin
        done = 1'b1;
        if (nf == 0) chk({tag, " done_lat"}, c, 0);
        else chk({tag, " done_with_f0"}, (bus.bt_valid && bus.bt_frame == 0), 1);
        chk({tag, " best_score"}, bus.best_score, m_score);
      end
    end
    chk({tag, " done_seen"}, done, 1);
    chk({tag, " count"}, n, nf);
    step();
    chk({tag, " idle"}, bus.busy, 0);
  endtask

  initial begin
    dvec_t  tbl [3];
    frame_t z;
    int     seen;
    bit     stray;

    rst = 1'b1;
    bus.seq_start = 1'b0; bus.seq_end = 1'b0; bus.ll_valid = 1'b0;
    bus.ll_index = '0; bus.ll_in = '0; bus.frame_done = 1'b0;
    step();
    chk("rst busy", bus.busy, 0);
    chk("rst best_score", bus.best_score, 0);
    chk("rst bt_valid", bus.bt_valid, 0);
    chk("rst bt_done", bus.bt_done, 0);
    chk("rst err", bus.err, 0);
    rst = 1'b0;
    step();

    for (int k = 0; k < NS; k++) z[k] = 0;
    tbl[0] = '{nf: 1, f0: z, f1: z, score: 0, p0: 0, p1: 0};
    for (int k = 0; k < NS; k++) tbl[0].f0[k] = -100 * k;
    tbl[1] = '{nf: 2, f0: z, f1: z, score: -10, p0: 0, p1: 0};
    tbl[2] = '{nf: 2, f0: z, f1: z, score: 30, p0: 1, p1: 0};
    tbl[2].f1[1] = 50;

    for (int i = 0; i < 3; i++) begin
      start_seq();
      chk($sformatf("dir%0d busy", i), bus.busy, 1);
      send_frame(tbl[i].f0, 1'b1);
      if (tbl[i].nf == 2) send_frame(tbl[i].f1, 1'b1);
      m_score = tbl[i].score;
      m_path.delete();
      m_path.push_back(tbl[i].p0);
      if (tbl[i].nf == 2) m_path.push_back(tbl[i].p1);
      end_and_collect($sformatf("dir%0d", i));
    end

    for (int r = 0; r < 8; r++) begin
      int nf = $urandom_range(1, 6);
      start_seq();
      for (int t = 0; t < nf; t++) send_frame(rand_frame(), 1'b1);
      run_model();
      end_and_collect($sformatf("rnd%0d", r));
    end

    start_seq();
    run_model();
    end_and_collect("empty");

    // Out-of-order index: sticky err, frame discarded, count unchanged.
    start_seq();
    chk("idx err_clear", bus.err, 0);
    send_frame(rand_frame(), 1'b1);
    bus.ll_valid = 1'b1; bus.ll_index = 16'd0; bus.ll_in = 64'sd5; step();
    bus.ll_index = 16'd2; step();
    bus.ll_valid = 1'b0;
    step();
    chk("idx err_set", bus.err, 1);
    bus.frame_done = 1'b1; step();
    bus.frame_done = 1'b0; step();
    send_frame(rand_frame(), 1'b1);
    run_model();
    end_and_collect("idx");
    chk("idx err_sticky", bus.err, 1);
    start_seq();
    chk("idx err_cleared_by_start", bus.err, 0);

    mf.delete();
    for (int t = 0; t < MAXF; t++) send_frame(rand_frame(), 1'b1);
    chk("ovf err_before", bus.err, 0);
    send_frame(rand_frame(), 1'b0);
    chk("ovf err_after", bus.err, 1);
    run_model();
    end_and_collect("ovf");

    // Reset during the third backtrace element.
    start_seq();
    for (int t = 0; t < 4; t++) send_frame(rand_frame(), 1'b1);
    bus.seq_end = 1'b1;
    seen = 0;
    for (int c = 0; c < 20 && seen < 3; c++) begin
      step();
      bus.seq_end = 1'b0;
      if (bus.bt_valid) seen++;
    end
    chk("abort third_valid_seen", seen, 3);
    rst = 1'b1;
    #1;
    chk("abort busy", bus.busy, 0);
    chk("abort bt_valid", bus.bt_valid, 0);
    chk("abort bt_done", bus.bt_done, 0);
    chk("abort best_score", bus.best_score, 0);
    chk("abort bt_state", bus.bt_state, 0);
    chk("abort bt_frame", bus.bt_frame, 0);
    chk("abort err", bus.err, 0);
    step();
    rst = 1'b0;
    stray = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      if (bus.bt_valid || bus.bt_done) stray = 1'b1;
    end
    chk("abort no_output_after", stray, 0);
    start_seq();
    send_frame(rand_frame(), 1'b1);
    run_model();
    end_and_collect("post_abort");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
